// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader.
//   state_t      : controller states (ST_IDLE, ST_RUN, ST_DRAIN)
//   BUF_DEPTH    : entries in the read-return buffer; also the read credit limit
//   cnt_width()  : bits needed to count 0..depth inclusive
//   BUF_CNT_W    : width of the buffer occupancy counter
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int BUF_CNT_W = cnt_width(BUF_DEPTH);

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// rd_skid_fifo: BUF_DEPTH-entry register FIFO for {last, data} beats.
// The head is always entry 0; a pop shifts the entries down and a push
// writes just above the surviving entries, so simultaneous push/pop keeps
// order with occupancy unchanged. Entries above the count stay zero, and
// head reads zero when empty.
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   push, wdata: write request and entry
//   pop        : remove the head (ignored when empty)
//   count      : occupancy 0..BUF_DEPTH
//   head       : oldest entry, zero when empty
module rd_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [BUF_CNT_W-1:0] count,
    output logic [WIDTH-1:0]     head
);

    logic [WIDTH-1:0]     mem [BUF_DEPTH];
    logic                 do_pop;
    logic                 do_push;
    logic [BUF_CNT_W-1:0] wr_idx;

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is dropped; the reader's credit rule never asks for it.
    assign do_push = push && (do_pop || (count != BUF_CNT_W'(BUF_DEPTH)));
    assign wr_idx  = do_pop ? (count - 1'b1) : count;
    assign head    = (count != '0) ? mem[0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[BUF_DEPTH-1] <= '0;
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (do_push && (wr_idx == BUF_CNT_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
            count <= count + BUF_CNT_W'(do_push) - BUF_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of consecutive RAM words through one
// synchronous RAM port (1-cycle registered read data) and presents them as
// a valid/ready stream with a last-beat flag.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : command pulse, sampled only in IDLE
//   base_addr, length : burst first address and word count (0..2**ADDR_WIDTH)
//   busy, done        : burst active; one-cycle completion pulse
//   mem_en, mem_addr  : read issue strobe and registered read address
//   mem_rdata         : registered RAM read data
//   m_valid, m_data, m_last, m_ready : output stream
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam logic [BUF_CNT_W:0]  BUF_LIMIT = (BUF_CNT_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_LEFT  = (ADDR_WIDTH + 1)'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    done_r;
    logic                    done_nxt;
    logic                    accept;
    logic                    issue;
    logic [BUF_CNT_W:0]      credits_used;
    logic                    rd_vld_p1;
    logic                    rd_last_p1;
    logic [BUF_CNT_W-1:0]    occ;
    logic [DATA_WIDTH:0]     head;

    assign accept       = (state == ST_IDLE) && start && (length != '0);
    // Credits count buffered beats plus the read whose data arrives next edge;
    // only registered state feeds this, so m_ready never reaches mem_en.
    assign credits_used = {1'b0, occ} + {{BUF_CNT_W{1'b0}}, rd_vld_p1};
    assign issue        = (state == ST_RUN) && (remaining != '0) && (credits_used < BUF_LIMIT);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (length == '0)) begin
                    done_nxt = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (remaining == ONE_LEFT)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Buffer empty with nothing in flight means the last beat has gone.
                if ((occ == '0) && !rd_vld_p1) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: address issue and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done_r    <= 1'b0;
            rd_ptr    <= '0;
            remaining <= '0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
            if (accept) begin
                rd_ptr    <= base_addr;
                remaining <= length;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Stage p1: RAM is returning data for the read issued last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue && (remaining == ONE_LEFT);
        end
    end

    // Stage p2: captured beats wait in the buffer for the consumer
    rd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld_p1),
        .wdata ({rd_last_p1, mem_rdata}),
        .pop   (m_valid && m_ready),
        .count (occ),
        .head  (head)
    );

    assign mem_en   = issue;
    assign mem_addr = rd_ptr;
    assign busy     = (state != ST_IDLE);
    assign done     = done_r;
    assign m_valid  = (occ != '0);
    assign m_data   = head[DATA_WIDTH-1:0];
    assign m_last   = head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_en, m_valid, m_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    // Synchronous RAM with registered read data
    logic [DW-1:0] ram [NW];
    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    // Reference model: beats and addresses a burst must produce, in order
    logic [DW:0]   exp_beats [$];
    logic [AW-1:0] exp_addr  [$];
    logic [DW:0]   got_log   [$];
    logic [AW-1:0] addr_log  [$];
    int reads, taken, done_seen;
    int checks, failures;
    int fv, de, ds0, r0, t0;
    logic [DW:0]   t1_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) begin
                if (exp_beats.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", m_data, $time);
                end else begin
                    chk("m_data", m_data, exp_beats[0][DW-1:0]);
                    chk("m_last", m_last, exp_beats[0][DW]);
                    if (m_ready) begin
                        got_log.push_back({m_last, m_data});
                        void'(exp_beats.pop_front());
                        taken++;
                    end
                end
            end else begin
                chk("m_data_empty", m_data, 0);
            end
            if (mem_en) begin
                addr_log.push_back(mem_addr);
                reads++;
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read: got addr %0h expected no read at %0t", mem_addr, $time);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
                end
            end
            checks++;
            if (reads - taken > 3) begin
                failures++;
                $display("FAIL credit_bound: got %0d outstanding expected at most 3", reads - taken);
            end
            if (done) done_seen++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // mode 0: m_ready=1; mode 1: random; mode 2: stall 6 cycles after first beat
    task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode,
                             input bit pulses, output int first_valid, output int done_edge);
        int edges, stall, empty_edge, tk0;
        bit got_done;
        for (int i = 0; i < len; i++) begin
            exp_beats.push_back({(i == len - 1), ram[(int'(b) + i) % NW]});
            exp_addr.push_back(AW'((int'(b) + i) % NW));
        end
        start = 1'b1; base_addr = b; length = (AW+1)'(len);
        m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        tk0 = taken;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1; stall = 0; empty_edge = -1; first_valid = -1; done_edge = -1; got_done = 0;
        while (edges < 400) begin
            if (m_valid && first_valid < 0) first_valid = edges;
            if (exp_beats.size() == 0 && empty_edge < 0) empty_edge = edges;
            if (done) begin
                got_done = 1;
                break;
            end
            chk("busy_active", busy, 1);
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (taken - tk0 >= 1 && stall < 6) begin
                        m_ready = 1'b0;
                        stall++;
                        if (stall == 6) begin
                            chk("stall_no_issue", mem_en, 0);
                            chk("stall_valid", m_valid, 1);
                            chk("stall_head", m_data, 8'h11);
                        end
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
            if (pulses) begin
                start = ($urandom_range(0, 2) == 0);
                base_addr = AW'($urandom_range(0, NW - 1));
                length = (AW+1)'($urandom_range(0, NW));
            end
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
        end
        chk("done_seen", got_done, 1);
        if (got_done) chk("done_latency", edges - empty_edge, 1);
        chk("beats_left", exp_beats.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        chk("busy_at_done", busy, 0);
        done_edge = edges;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; reads = 0; taken = 0; done_seen = 0;
        t1_exp = '{9'h012, 9'h013, 9'h014, 9'h115};
        for (int i = 0; i < NW; i++) ram[i] = DW'(i + 16);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic burst: 12,13,14,15 back to back
        got_log.delete(); ds0 = done_seen;
        run_burst(4'd2, 4, 0, 0, fv, de);
        chk("t1_first_valid_edge", fv, 3);
        chk("t1_done_edge", de, 8);
        idle(1);
        chk("t1_done_one_cycle", done, 0);
        chk("t1_done_count", done_seen - ds0, 1);
        chk("t1_beats", got_log.size(), 4);
        for (int k = 0; k < 4 && k < got_log.size(); k++) chk("t1_beat", got_log[k], t1_exp[k]);

        // Address wrap
        got_log.delete(); addr_log.delete();
        run_burst(4'd14, 4, 0, 0, fv, de);
        idle(1);
        chk("t2_reads", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("t2_a0", addr_log[0], 14); chk("t2_a1", addr_log[1], 15);
            chk("t2_a2", addr_log[2], 0);  chk("t2_a3", addr_log[3], 1);
        end
        if (got_log.size() == 4) begin
            chk("t2_d0", got_log[0], 9'h01E); chk("t2_d2", got_log[2], 9'h010);
            chk("t2_d3", got_log[3], 9'h111);
        end

        // Backpressure
        got_log.delete();
        run_burst(4'd0, 8, 2, 0, fv, de);
        idle(1);
        chk("t3_beats", got_log.size(), 8);
        for (int k = 0; k < got_log.size() && k < 8; k++)
            chk("t3_order", got_log[k][DW-1:0], 32'h10 + k);

        // Zero length
        ds0 = done_seen; r0 = reads;
        start = 1'b1; base_addr = 4'd7; length = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_mem_en", mem_en, 0);
        @(posedge clk); #1;
        chk("t4_done_drop", done, 0);
        idle(2);
        chk("t4_done_count", done_seen - ds0, 1);
        chk("t4_no_reads", reads - r0, 0);

        // Start pulses during a 16-word burst are ignored
        got_log.delete();
        run_burst(4'd3, 16, 1, 1, fv, de);
        idle(1);
        chk("t4_exact16", got_log.size(), 16);

        // Full-depth burst with wrap
        got_log.delete(); addr_log.delete();
        run_burst(4'd5, 16, 1, 0, fv, de);
        idle(1);
        chk("t5_reads", addr_log.size(), 16);
        if (addr_log.size() == 16) begin
            chk("t5_a0", addr_log[0], 5); chk("t5_a10", addr_log[10], 15);
            chk("t5_a11", addr_log[11], 0); chk("t5_a15", addr_log[15], 4);
        end
        if (got_log.size() == 16) chk("t5_last", got_log[15], 9'h114);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 8; i++) begin
            exp_beats.push_back({(i == 7), ram[i]});
            exp_addr.push_back(AW'(i));
        end
        t0 = taken;
        start = 1'b1; base_addr = '0; length = 5'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && (taken - t0) < 3; c++) begin
            @(posedge clk); #1;
        end
        chk("t6_reached_beat3", taken - t0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", m_valid, 0);
        chk("t6_busy_drop", busy, 0);
        chk("t6_mem_en_drop", mem_en, 0);
        chk("t6_m_data_zero", m_data, 0);
        exp_beats.delete(); exp_addr.delete();
        reads = 0; taken = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        got_log.delete();
        run_burst(4'd9, 5, 1, 0, fv, de);
        idle(1);
        chk("t6_after_beats", got_log.size(), 5);
        if (got_log.size() == 5) begin
            chk("t6_first", got_log[0], 9'h019);
            chk("t6_last", got_log[4], 9'h11D);
        end

        // Random bursts, odd ones back to back with the previous done
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NW; i++) ram[i] = DW'($urandom_range(0, 255));
            run_burst(AW'($urandom_range(0, NW - 1)), $urandom_range(1, NW), 1, 0, fv, de);
            if (r % 2 == 0) idle(2);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the team's synchronous dual-port RAM. It drives one RAM port's address and consumes that port's registered read data, which has 1-cycle latency.
- On a start command it reads a burst of consecutive words and presents them as a valid/ready stream with a last-beat flag.
- A 3-entry buffer absorbs downstream backpressure without losing words already in flight from the RAM.

Parameters:
- DATA_WIDTH, 8, width of a RAM word and of the stream data.
- ADDR_WIDTH, 4, RAM address width; the RAM holds 2**ADDR_WIDTH words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; latched on an accepted start.
- length  in  ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH; latched on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the burst completes.
- mem_en  out  1  high in cycles where a read is issued. Informational; the RAM port's write enable is tied low externally.
- mem_addr  out  ADDR_WIDTH  RAM read address; driven directly from a register.
- mem_rdata  in  DATA_WIDTH  RAM registered read data.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data; head of the buffer.
- m_last  out  1  marks the final beat of the burst; qualified by m_valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; the buffer and in-flight flag are cleared. busy, done, mem_en, mem_addr, m_valid, m_data and m_last are all 0. Reset mid-burst aborts the burst; the lost beats are never emitted.
- Beat transfer: m_valid and m_ready both high at a rising edge. m_valid, m_data and m_last hold while m_valid=1 and m_ready=0.
- States: IDLE, RUN, DRAIN.
- IDLE with start=1 and length>0:
  - latch rd_ptr=base_addr and remaining=length;
  - next state RUN; busy=1.
- IDLE with start=1 and length=0:
  - no reads and no beats;
  - done pulses for one cycle, starting in the cycle after the start edge;
  - busy stays 0.
- RUN, issue rule: issue = (remaining>0) and (occupancy + inflight < 3). Occupancy is the buffer count (0..3) and inflight is a 1-bit register. The rule uses registered state only, so there is no m_ready-to-mem_en path.
- RUN, on issue:
  - mem_en=1 and mem_addr=rd_ptr;
  - rd_ptr increments modulo 2**ADDR_WIDTH (15 wraps to 0);
  - remaining decrements;
  - inflight is set next cycle, tagged last if remaining was 1.
- RUN exit: when the final read issues, next state is DRAIN.
- Capture: when inflight=1, mem_rdata and its last tag are pushed into the buffer at that edge. Issue-to-push is 2 edges: the RAM samples the address at edge 1 and the buffer captures at edge 2.
- Simultaneous push and pop in one cycle: occupancy unchanged and ordering preserved. The credit rule guarantees a push never hits a full buffer; an overflow is a design error, and the bench asserts against it.
- Sustained m_ready=1: one beat per cycle after the initial 2-cycle fill latency. The first m_valid appears 2 edges after the first issue, i.e. 3 edges after the start edge.
- DRAIN exit: when the buffer is empty, inflight=0, and the last beat has transferred. Then done pulses for 1 cycle, busy falls in the same cycle, and next state is IDLE.
- start is ignored whenever busy=1.
- A new start is accepted on the cycle done is high. Back-to-back bursts are therefore possible with a 1-cycle gap.
- m_data reads 0 when the buffer is empty.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DRAIN;
  - BUF_DEPTH=3;
  - a width helper for the occupancy counter.
- One sub-module, rd_skid_fifo: 3-entry register FIFO of {last, data} with push, pop, count, head outputs and active-low async reset.
- The top level holds the FSM, rd_ptr, remaining, and inflight/credit logic.

Test Plan:
- RAM preloaded ram[i]=i+8'h10; base=2, length=4, m_ready=1 -> beats 12,13,14,15 on 4 consecutive cycles; m_last only on 15; done pulses once; busy returns to 0.
- base=14, length=4 -> mem_addr sequence 14,15,0,1; data 1E,1F,10,11; no extra reads.
- length=8 with m_ready=0 for 6 cycles after the first beat -> mem_en stops once occupancy+inflight=3; the buffer never exceeds 3; the full sequence 10..17 is delivered in order with no loss or duplication.
- length=0 -> done pulses the cycle after start; no mem_en, no m_valid; start pulses during an active 16-word burst are ignored (exactly 16 beats).
- length=16, base=5 -> all 16 words delivered, addresses 5..15 then 0..4; the last beat carries m_last.
- rst_n asserted asynchronously mid-burst (beat 3 of 8) -> m_valid, busy, mem_en drop immediately without waiting for a clock edge; a new burst after release is delivered correctly from its own base.
